// File: rtl/hand_collector.sv
// rtl/hand_collector.sv - collects five cards into a hand for the rank evaluator
// Optional duplicate-card rejection enabled by defining HAND_COLLECTOR_DUP_CHECK_EN.
module hand_collector #(
  parameter int MAX_RANK = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] card_in,
  input  logic       card_valid,
  output logic       card_ready,
  input  logic       clear,
  output logic [5:0] hand_out [4:0],
  output logic       hand_valid,
  input  logic       hand_ready,
  output logic [2:0] card_count,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t state, state_n;
  logic   take, bad_rank, dup, reject, accept;

  always_comb begin
    state_n    = state;
    card_ready = (state == COLLECT);
    hand_valid = (state == PRESENT);
    // clear drops any offered card without raising an error
    take       = card_valid && card_ready && !clear;
    bad_rank   = (card_in[5:2] > 4'(MAX_RANK));
    dup        = 1'b0;
`ifdef HAND_COLLECTOR_DUP_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      if ((3'(i) < card_count) && (hand_out[i] == card_in)) dup = 1'b1;
    end
`endif
    reject = take && (bad_rank || dup);
    accept = take && !reject;
    case (state)
      COLLECT: if (accept && card_count == 3'd4) state_n = PRESENT;
      PRESENT: if (hand_ready) state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
    if (clear) state_n = COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      card_count <= 3'd0;
      err_pulse  <= 1'b0;
      err_code   <= 2'b00;
      for (int i = 0; i < 5; i++) hand_out[i] <= 6'h00;
    end else if (clear) begin
      state      <= COLLECT;
      card_count <= 3'd0;
      err_pulse  <= 1'b0;
    end else begin
      state     <= state_n;
      err_pulse <= reject;
      // bad rank outranks duplicate when both apply
      if (reject) err_code <= bad_rank ? 2'b01 : 2'b10;
      if (hand_valid && hand_ready) begin
        card_count <= 3'd0;
      end else if (accept) begin
        card_count <= card_count + 3'd1;
        for (int i = 0; i < 5; i++) begin
          if (card_count == 3'(i)) hand_out[i] <= card_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_hand_collector.sv
// tb/tb_hand_collector.sv - directed self-checking bench for hand_collector
module tb_hand_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] card_in = 6'h00;
  logic       card_valid = 1'b0;
  logic       card_ready;
  logic       clear = 1'b0;
  logic [5:0] hand_out [4:0];
  logic       hand_valid;
  logic       hand_ready = 1'b0;
  logic [2:0] card_count;
  logic       err_pulse;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  logic [5:0] hand_cards [5] = '{6'h30, 6'h2D, 6'h2A, 6'h26, 6'h22};

  hand_collector #(.MAX_RANK(12)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_valid(card_valid),
    .card_ready(card_ready), .clear(clear), .hand_out(hand_out),
    .hand_valid(hand_valid), .hand_ready(hand_ready), .card_count(card_count),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] c);
    card_in    = c;
    card_valid = 1'b1;
    step();
    card_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, card_count, 0);
    check({tag, "_ready"}, card_ready, 1);
    check({tag, "_hvalid"}, hand_valid, 0);
    check({tag, "_epulse"}, err_pulse, 0);
    check({tag, "_ecode"}, err_code, 0);
    for (int i = 0; i < 5; i++) check({tag, "_slot"}, hand_out[i], 0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // five legal cards back to back
    card_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      card_in = hand_cards[i];
      step();
      if (i < 4) check("collect_count", card_count, i + 1);
    end
    card_valid = 1'b0;
    check("hand_valid", hand_valid, 1);
    check("full_count", card_count, 5);
    check("full_ready", card_ready, 0);
    for (int i = 0; i < 5; i++) check("hand_slot", hand_out[i], hand_cards[i]);

    // downstream stalls while a card is offered; offer is ignored
    card_in    = 6'h10;
    card_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_ready", card_ready, 0);
      check("stall_slot0", hand_out[0], 6'h30);
      check("stall_slot4", hand_out[4], 6'h22);
      check("stall_count", card_count, 5);
      check("stall_epulse", err_pulse, 0);
    end
    card_valid = 1'b0;
    hand_ready = 1'b1;
    step();
    hand_ready = 1'b0;
    check("handoff_count", card_count, 0);
    check("handoff_ready", card_ready, 1);
    check("handoff_hvalid", hand_valid, 0);

    // bad rank, then back-to-back bad ranks
    offer(6'h34);
    check("badrank_pulse", err_pulse, 1);
    check("badrank_code", err_code, 1);
    check("badrank_count", card_count, 0);
    step();
    check("badrank_pulse_end", err_pulse, 0);
    check("badrank_code_held", err_code, 1);
    card_in    = 6'h3C;
    card_valid = 1'b1;
    step();
    check("b2b_pulse1", err_pulse, 1);
    step();
    check("b2b_pulse2", err_pulse, 1);
    card_valid = 1'b0;
    step();
    check("b2b_pulse_end", err_pulse, 0);

    // duplicate card
    offer(6'h30);
    offer(6'h30);
`ifdef HAND_COLLECTOR_DUP_CHECK_EN
    check("dup_count", card_count, 1);
    check("dup_pulse", err_pulse, 1);
    check("dup_code", err_code, 2);
`else
    check("dup_count", card_count, 2);
    check("dup_pulse", err_pulse, 0);
    check("dup_code", err_code, 1);
    check("dup_slot1", hand_out[1], 6'h30);
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_count", card_count, 0);
    check("clear_ready", card_ready, 1);

    // clear together with the fifth card
    for (int i = 0; i < 4; i++) offer(hand_cards[i]);
    check("pre_clear_count", card_count, 4);
    card_in    = hand_cards[4];
    card_valid = 1'b1;
    clear      = 1'b1;
    step();
    card_valid = 1'b0;
    clear      = 1'b0;
    check("clr5_count", card_count, 0);
    check("clr5_hvalid", hand_valid, 0);
    check("clr5_epulse", err_pulse, 0);
    check("clr5_ready", card_ready, 1);
    step();
    check("clr5_hvalid_later", hand_valid, 0);

    // clear together with a bad-rank card raises no error
    card_in    = 6'h38;
    card_valid = 1'b1;
    clear      = 1'b1;
    step();
    card_valid = 1'b0;
    clear      = 1'b0;
    check("clr_bad_epulse", err_pulse, 0);

    // reset mid-hand
    for (int i = 0; i < 3; i++) offer(hand_cards[i]);
    check("pre_rst_count", card_count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
